// File: rtl/tff_pkg.sv
// tff_pkg
// Shared constants for the T flip-flop sequence controller: operation
// mode codes, FSM state codes and the default bank width.
package tff_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Operation requested alongside start
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Controller FSM states, binary encoded
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // True for the two modes that step the bank through the counter
  function automatic logic is_count_mode(input logic [1:0] m);
    return (m == MODE_UP) || (m == MODE_DOWN);
  endfunction

endpackage

// File: rtl/tff_rst.sv
// tff_rst
// Single T flip-flop with synchronous active-high reset.
// Ports:
//   q   - output, flip-flop state
//   t   - input, toggle enable: q inverts on the next rising edge when high
//   clk - input, clock
//   rst - input, synchronous active-high reset, forces q to 0
module tff_rst (
  output logic q,
  input  logic t,
  input  logic clk,
  input  logic rst
);

  // Reset wins; otherwise invert when toggle is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_seq_ctrl.sv
// tff_seq_ctrl
// Controller that drives a bank of WIDTH T flip-flops. A start request in
// IDLE latches the operation and then the bank either counts up/down for a
// given number of steps, loads a target value in one cycle, or holds.
// Completion is signalled by a one-cycle done pulse.
// Ports:
//   clk       - input, system clock, rising edge
//   rst       - input, synchronous active-high reset
//   start     - input, one-cycle request, only honoured in IDLE
//   mode      - input [1:0], 00 up, 01 down, 10 load target, 11 hold
//   target    - input [WIDTH-1:0], value loaded by mode 10
//   count_len - input [7:0], number of count steps for modes 00/01
//   q         - output [WIDTH-1:0], current bank state
//   t_vec     - output [WIDTH-1:0], toggle vector applied to the bank
//   busy      - output, high while in RUN or LOAD
//   done      - output, one-cycle completion pulse
module tff_seq_ctrl
  import tff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  input  logic [7:0]       count_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] target_r;
  logic [7:0]       steps_r;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] down_t;

  // The bank itself: one T flip-flop per bit
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bank
      tff_rst u_tff (
        .q   (q[gi]),
        .t   (t_vec[gi]),
        .clk (clk),
        .rst (rst)
      );
    end
  endgenerate

  // Ripple-carry style toggle patterns: for counting up a bit toggles when
  // all lower bits are one; for counting down when all lower bits are zero.
  // A scalar running product avoids a vector that depends on itself.
  always_comb begin
    logic all_ones;
    logic all_zeros;
    up_t      = '0;
    down_t    = '0;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i]   = all_ones;
      down_t[i] = all_zeros;
      all_ones  = all_ones & q[i];
      all_zeros = all_zeros & ~q[i];
    end
  end

  // Toggle vector selection: only RUN and LOAD ever move the bank.
  // LOAD flips exactly the bits that differ from the latched target.
  always_comb begin
    t_vec = '0;
    case (state)
      ST_RUN:  t_vec = (mode_r == MODE_DOWN) ? down_t : up_t;
      ST_LOAD: t_vec = q ^ target_r;
      default: t_vec = '0;
    endcase
  end

  assign busy = (state == ST_RUN) || (state == ST_LOAD);
  assign done = (state == ST_DONE);

  // FSM, operation latches and step counter. The counter holds the number
  // of RUN edges still to come, so the edge that takes it from 1 to 0 is
  // the last count step and also the transition into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_r   <= '0;
      target_r <= '0;
      steps_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_r   <= mode;
            target_r <= target;
            steps_r  <= count_len;
            if (is_count_mode(mode)) begin
              state <= (count_len != 8'd0) ? ST_RUN : ST_DONE;
            end else if (mode == MODE_LOAD) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          steps_r <= steps_r - 8'd1;
          if (steps_r == 8'd1) begin
            state <= ST_DONE;
          end
        end
        ST_LOAD: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// tb_tff_seq_ctrl
// Self-checking bench for tff_seq_ctrl with WIDTH=4. Expected values come
// from an arithmetic model of the bank value (add/subtract modulo 16,
// toggle vector = current XOR next value).
module tb_tff_seq_ctrl;

  localparam int W    = 4;
  localparam int MASK = 15;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] target;
  logic [7:0]   count_len;
  logic [W-1:0] q;
  logic [W-1:0] t_vec;
  logic         busy;
  logic         done;

  int vectors;
  int miscompares;
  int model_q;

  tff_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .target    (target),
    .count_len (count_len),
    .q         (q),
    .t_vec     (t_vec),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Next bank value for a count step
  function automatic int nextVal(input int cur, input logic [1:0] m);
    if (m == 2'b01) return (cur + MASK) & MASK;
    return (cur + 1) & MASK;
  endfunction

  // Compare all outputs against expectations, one vector per call
  task automatic checkOutput(input string tag, input int eq, input int et,
                             input bit eb, input bit ed);
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_t;
    exp_q = eq[W-1:0];
    exp_t = et[W-1:0];
    vectors++;
    assert ({q, t_vec, busy, done} === {exp_q, exp_t, eb, ed})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed q=%0d t_vec=%0d busy=%b done=%b, expected q=%0d t_vec=%0d busy=%b done=%b",
             tag, q, t_vec, busy, done, exp_q, exp_t, eb, ed);
    end
  endtask

  // Present a start request for the coming edge
  task automatic applyStimulus(input logic [1:0] m, input logic [W-1:0] tg,
                               input logic [7:0] len);
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    target    = tg;
    count_len = len;
  endtask

  // Drive the inputs for the coming edge while an operation is underway;
  // with junk set, random starts and input changes must all be ignored
  task automatic driveJunk(input bit junk);
    @(negedge clk);
    if (junk) begin
      start     = 1'($urandom);
      mode      = 2'($urandom);
      target    = W'($urandom);
      count_len = 8'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  // Run one complete operation from IDLE back to IDLE, checking every cycle
  task automatic runOp(input logic [1:0] m, input logic [W-1:0] tg,
                       input logic [7:0] len, input bit junk);
    int cur;
    cur = model_q;
    applyStimulus(m, tg, len);
    @(posedge clk); #1;
    if ((m == 2'b00 || m == 2'b01) && len != 8'd0) begin
      checkOutput("run_first", cur, cur ^ nextVal(cur, m), 1'b1, 1'b0);
      for (int k = 1; k <= int'(len); k++) begin
        driveJunk(junk);
        @(posedge clk); #1;
        cur = nextVal(cur, m);
        if (k < int'(len)) checkOutput("run_step", cur, cur ^ nextVal(cur, m), 1'b1, 1'b0);
        else               checkOutput("run_done", cur, 0, 1'b0, 1'b1);
      end
    end else if (m == 2'b10) begin
      checkOutput("load_cycle", cur, cur ^ int'(tg), 1'b1, 1'b0);
      driveJunk(junk);
      @(posedge clk); #1;
      cur = int'(tg);
      checkOutput("load_done", cur, 0, 1'b0, 1'b1);
    end else begin
      checkOutput("nop_done", cur, 0, 1'b0, 1'b1);
    end
    driveJunk(junk);
    @(posedge clk); #1;
    checkOutput("idle_return", cur, 0, 1'b0, 1'b0);
    start   = 1'b0;
    model_q = cur;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_q     = 0;
    rst         = 1'b1;
    start       = 1'b0;
    mode        = 2'b00;
    target      = '0;
    count_len   = 8'd0;

    // Two reset cycles
    @(posedge clk); #1;
    checkOutput("reset_1", 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("reset_2", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Count up five steps: 1..5
    runOp(2'b00, 4'd0, 8'd5, 1'b0);
    // Back to zero, then count down three with wrap: 15,14,13
    runOp(2'b10, 4'd0, 8'd0, 1'b0);
    runOp(2'b01, 4'd0, 8'd3, 1'b0);
    // Load 6 from 13: toggle vector 11
    runOp(2'b10, 4'd6, 8'd0, 1'b0);
    // Zero-length count and hold leave the bank alone
    runOp(2'b00, 4'd9, 8'd0, 1'b0);
    runOp(2'b11, 4'd9, 8'd7, 1'b0);
    // Up-count wrap from 14 through 0
    runOp(2'b10, 4'd14, 8'd0, 1'b0);
    runOp(2'b00, 4'd0, 8'd4, 1'b0);

    // Ten-step count, second start at step 3, reset at step 6
    runOp(2'b10, 4'd0, 8'd0, 1'b0);
    applyStimulus(2'b00, 4'd0, 8'd10);
    @(posedge clk); #1;
    checkOutput("abort_first", 0, 1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start     = (k == 3);
      mode      = 2'b10;
      target    = 4'd9;
      count_len = 8'd2;
      @(posedge clk); #1;
      checkOutput("abort_step", k, k ^ ((k + 1) & MASK), 1'b1, 1'b0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("abort_idle", 0, 0, 1'b0, 1'b0);
    end
    model_q = 0;

    // Reset beats a simultaneous start
    runOp(2'b10, 4'd5, 8'd0, 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    start     = 1'b1;
    mode      = 2'b00;
    count_len = 8'd4;
    @(posedge clk); #1;
    checkOutput("rst_priority", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_priority_idle", 0, 0, 1'b0, 1'b0);
    model_q = 0;

    // Randomized operations with noisy inputs while busy
    for (int n = 0; n < 40; n++) begin
      logic [1:0]   rm;
      logic [W-1:0] rt;
      logic [7:0]   rl;
      rm = 2'($urandom);
      rt = W'($urandom);
      rl = 8'($urandom_range(0, 20));
      runOp(rm, rt, rl, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tff_seq_ctrl.md
TFF_SEQ_CTRL -- requirements
Module: tff_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, number of T flip-flop bits in the controlled bank.
REQ-002 CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-005 MODE  input  2  operation: 00 count up, 01 count down, 10 load TARGET, 11 hold.
REQ-006 TARGET  input  WIDTH  load value for MODE=10.
REQ-007 COUNT_LEN  input  8  number of count steps for MODE=00/01.
REQ-008 Q  output  WIDTH  current bank state, bit i = Q of flip-flop i.
REQ-009 T_VEC  output  WIDTH  toggle vector currently driven to the bank (debug/observe).
REQ-010 BUSY  output  1  high in RUN and LOAD states.
REQ-011 DONE  output  1  one-cycle completion pulse.

Function
REQ-012 FSM states: IDLE, RUN, LOAD, DONE; encoding binary, 2 bits.
REQ-013 IDLE: T_VEC=0; START=1 latches MODE, TARGET, COUNT_LEN into internal registers at that edge.
REQ-014 IDLE transitions on START: MODE 00/01 with COUNT_LEN>0 -> RUN; COUNT_LEN=0 -> DONE; MODE 10 -> LOAD; MODE 11 -> DONE.
REQ-015 RUN up: T_VEC[0]=1, T_VEC[i]=AND of Q[i-1:0]; bank increments by 1 per edge, mod 2^WIDTH.
REQ-016 RUN down: T_VEC[0]=1, T_VEC[i]=AND of ~Q[i-1:0]; bank decrements by 1 per edge, mod 2^WIDTH.
REQ-017 Wrap-around: up from all-ones gives zero; down from zero gives all-ones; no flag, no stall.
REQ-018 RUN step counter loaded with COUNT_LEN, decremented each RUN edge; on edge where it reaches 0, state -> DONE.
REQ-019 Latency: START sampled at edge n -> Q changes at edges n+1..n+COUNT_LEN; DONE high in cycle after edge n+COUNT_LEN.
REQ-020 LOAD: T_VEC = Q XOR latched TARGET for exactly one cycle; next edge Q=TARGET, state -> DONE.
REQ-021 DONE state: DONE=1, BUSY=0, T_VEC=0, lasts one cycle, then -> IDLE unconditionally.
REQ-022 START while BUSY or in DONE state is ignored; input changes after latching have no effect.
REQ-023 Hold (MODE=11): Q unchanged, DONE pulses one cycle after START edge.
REQ-024 T_VEC is combinational from state and Q; no glitch requirement beyond single-clock synchronous use.

Reset
REQ-025 RST=1 at an edge: Q=0, state IDLE, step counter 0, latched registers 0, BUSY=0, DONE=0, T_VEC=0.
REQ-026 RST mid-RUN/LOAD aborts operation; no DONE pulse generated for aborted operation.
REQ-027 RST has priority over START sampled at the same edge.

Structure
REQ-028 Shared package tff_pkg holds MODE codes (MODE_UP, MODE_DOWN, MODE_LOAD, MODE_HOLD) and FSM state constants.
REQ-029 Sub-module tff_rst: one T flip-flop with synchronous active-high RST, ports Q, T, CLK, RST; instantiated WIDTH times by generate.
REQ-030 Controller logic (FSM, step counter, T_VEC decode) in tff_seq_ctrl; no other sub-modules.

Verification
REQ-031 RST 2 cycles, then START MODE=00 COUNT_LEN=5 -> Q 1,2,3,4,5 on successive edges, BUSY 5 cycles, DONE one cycle, Q holds 5.
REQ-032 From Q=0, START MODE=01 COUNT_LEN=3 -> Q 15,14,13 (wrap), DONE pulse after third step.
REQ-033 Q=13, START MODE=10 TARGET=6 -> T_VEC=11 one cycle, Q=6 next edge, DONE next cycle.
REQ-034 START MODE=00 COUNT_LEN=0 and MODE=11 -> Q unchanged, BUSY never high, DONE one cycle after START.
REQ-035 START MODE=00 COUNT_LEN=10, second START at step 3, RST at step 6 -> second START ignored, Q=0 after RST edge, no DONE, IDLE.
